// File: rtl/parking_lane_if.sv
// Lane sensor / barrier bundle for parking_lane_ctrl.
// Optional status signals under PARKING_STATUS_EN.
interface parking_lane_if #(
   parameter int N_LANES = 2,
   parameter int CNT_W   = 8
);
   logic [N_LANES-1:0]   entry_sensor;
   logic [N_LANES-1:0]   exit_sensor;
   logic [N_LANES-1:0]   payment_complete;
   logic                 emergency;
   logic [N_LANES-1:0]   open_entry;
   logic [N_LANES-1:0]   open_exit;
   logic [N_LANES-1:0]   calculate_fee;
   logic [CNT_W-1:0]     occupancy;
   logic [CNT_W-1:0]     available_spaces;
   logic                 full;
   logic                 emergency_active;
`ifdef PARKING_STATUS_EN
   logic [2*N_LANES-1:0] timeout_pulse;
   logic                 count_err;

   modport slave (
      input  entry_sensor, exit_sensor, payment_complete, emergency,
      output open_entry, open_exit, calculate_fee, occupancy,
      output available_spaces, full, emergency_active,
      output timeout_pulse, count_err
   );
   modport master (
      output entry_sensor, exit_sensor, payment_complete, emergency,
      input  open_entry, open_exit, calculate_fee, occupancy,
      input  available_spaces, full, emergency_active,
      input  timeout_pulse, count_err
   );
`else
   modport slave (
      input  entry_sensor, exit_sensor, payment_complete, emergency,
      output open_entry, open_exit, calculate_fee, occupancy,
      output available_spaces, full, emergency_active
   );
   modport master (
      output entry_sensor, exit_sensor, payment_complete, emergency,
      input  open_entry, open_exit, calculate_fee, occupancy,
      input  available_spaces, full, emergency_active
   );
`endif
endinterface

// File: rtl/parking_lane_ctrl.sv
// Multi-lane parking gate controller with shared occupancy and emergency.
// PARKING_STATUS_EN adds timeout_pulse and sticky count_err outputs.
module parking_lane_ctrl #(
   parameter int N_LANES       = 2,
   parameter int CAPACITY      = 64,
   parameter int CNT_W         = 8,
   parameter int TO_W          = 8,
   parameter int ENTRY_TIMEOUT = 100,
   parameter int EXIT_TIMEOUT  = 100
) (
   input  logic          clk,
   input  logic          reset_n,
   parking_lane_if.slave bus
);
   typedef enum logic [2:0] {
      E_IDLE, E_OPEN, E_PASS, E_WAIT, E_EMERG
   } e_st_t;
   typedef enum logic [2:0] {
      X_IDLE, X_PAY, X_OPEN, X_PASS, X_WAIT, X_EMERG
   } x_st_t;

   localparam int AW = CNT_W + 2;
   localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
   localparam logic [TO_W-1:0]  ETO_M1 = TO_W'(ENTRY_TIMEOUT - 1);
   localparam logic [TO_W-1:0]  XTO_M1 = TO_W'(EXIT_TIMEOUT - 1);

   e_st_t            e_st_q  [N_LANES];
   e_st_t            e_st_d  [N_LANES];
   x_st_t            x_st_q  [N_LANES];
   x_st_t            x_st_d  [N_LANES];
   logic [TO_W-1:0]  e_cnt_q [N_LANES];
   logic [TO_W-1:0]  e_cnt_d [N_LANES];
   logic [TO_W-1:0]  x_cnt_q [N_LANES];
   logic [TO_W-1:0]  x_cnt_d [N_LANES];
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] avail_q, avail_d;
   logic             full_q, full_d;
   logic             emerg_q, emerg_d;
   logic [N_LANES-1:0] oe_q, oe_d;
   logic [N_LANES-1:0] ox_q, ox_d;
   logic [N_LANES-1:0] fee_q, fee_d;
   logic [N_LANES-1:0] e_to, x_to;
   logic [CNT_W-1:0] n_gnt;
   logic [AW-1:0]    occ_sum;
   logic             clamp;

   always_comb begin
      n_gnt   = '0;
      e_to    = '0;
      x_to    = '0;
      occ_sum = {2'b00, occ_q};
      emerg_d = bus.emergency;
      for (int i = 0; i < N_LANES; i++) begin
         e_st_d[i]  = e_st_q[i];
         x_st_d[i]  = x_st_q[i];
         e_cnt_d[i] = (e_st_q[i] == E_OPEN) ? e_cnt_q[i] + TO_W'(1) : '0;
         x_cnt_d[i] = (x_st_q[i] == X_OPEN) ? x_cnt_q[i] + TO_W'(1) : '0;
         if (bus.emergency) begin
            e_st_d[i] = E_EMERG;
            x_st_d[i] = X_EMERG;
         end else if (emerg_q) begin
            e_st_d[i] = E_WAIT;
            x_st_d[i] = X_WAIT;
         end else begin
            // grant budget is this cycle's free space; exits count next cycle
            unique case (e_st_q[i])
               E_IDLE:
                  if (bus.entry_sensor[i] && n_gnt < avail_q) begin
                     e_st_d[i] = E_OPEN;
                     n_gnt     = n_gnt + CNT_W'(1);
                     occ_sum   = occ_sum + AW'(1);
                  end
               E_OPEN:
                  if (!bus.entry_sensor[i]) begin
                     e_st_d[i] = E_PASS;
                  end else if (e_cnt_q[i] == ETO_M1) begin
                     e_st_d[i] = E_WAIT;
                     e_to[i]   = 1'b1;
                     occ_sum   = occ_sum - AW'(1);
                  end
               E_PASS: e_st_d[i] = E_IDLE;
               E_WAIT: if (!bus.entry_sensor[i]) e_st_d[i] = E_IDLE;
               default: e_st_d[i] = E_WAIT;
            endcase
            unique case (x_st_q[i])
               X_IDLE: if (bus.exit_sensor[i]) x_st_d[i] = X_PAY;
               X_PAY:
                  if (!bus.exit_sensor[i]) x_st_d[i] = X_IDLE;
                  else if (bus.payment_complete[i]) x_st_d[i] = X_OPEN;
               X_OPEN:
                  if (!bus.exit_sensor[i]) begin
                     x_st_d[i] = X_PASS;
                  end else if (x_cnt_q[i] == XTO_M1) begin
                     x_st_d[i] = X_WAIT;
                     x_to[i]   = 1'b1;
                  end
               X_PASS: begin
                  x_st_d[i] = X_IDLE;
                  occ_sum   = occ_sum - AW'(1);
               end
               X_WAIT: if (!bus.exit_sensor[i]) x_st_d[i] = X_IDLE;
               default: x_st_d[i] = X_WAIT;
            endcase
         end
         oe_d[i]  = (e_st_d[i] == E_OPEN) || (e_st_d[i] == E_EMERG);
         ox_d[i]  = (x_st_d[i] == X_OPEN) || (x_st_d[i] == X_EMERG);
         fee_d[i] = (x_st_d[i] == X_PAY);
      end
      clamp   = occ_sum[AW-1];
      occ_d   = clamp ? '0 : occ_sum[CNT_W-1:0];
      avail_d = CAP_C - occ_d;
      full_d  = (occ_d == CAP_C);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_LANES; i++) begin
            e_st_q[i]  <= E_IDLE;
            x_st_q[i]  <= X_IDLE;
            e_cnt_q[i] <= '0;
            x_cnt_q[i] <= '0;
         end
         occ_q   <= '0;
         avail_q <= CAP_C;
         full_q  <= 1'b0;
         emerg_q <= 1'b0;
         oe_q    <= '0;
         ox_q    <= '0;
         fee_q   <= '0;
      end else begin
         for (int i = 0; i < N_LANES; i++) begin
            e_st_q[i]  <= e_st_d[i];
            x_st_q[i]  <= x_st_d[i];
            e_cnt_q[i] <= e_cnt_d[i];
            x_cnt_q[i] <= x_cnt_d[i];
         end
         occ_q   <= occ_d;
         avail_q <= avail_d;
         full_q  <= full_d;
         emerg_q <= emerg_d;
         oe_q    <= oe_d;
         ox_q    <= ox_d;
         fee_q   <= fee_d;
      end
   end

   assign bus.open_entry       = oe_q;
   assign bus.open_exit        = ox_q;
   assign bus.calculate_fee    = fee_q;
   assign bus.occupancy        = occ_q;
   assign bus.available_spaces = avail_q;
   assign bus.full             = full_q;
   assign bus.emergency_active = emerg_q;

`ifdef PARKING_STATUS_EN
   logic [2*N_LANES-1:0] to_pulse_q, to_pulse_d;
   logic                 err_q, err_d;

   always_comb begin
      to_pulse_d = {x_to, e_to};
      err_d      = err_q | clamp;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_pulse_q <= '0;
         err_q      <= 1'b0;
      end else begin
         to_pulse_q <= to_pulse_d;
         err_q      <= err_d;
      end
   end

   assign bus.timeout_pulse = to_pulse_q;
   assign bus.count_err     = err_q;
`endif
endmodule

// File: doc/parking_lane_ctrl.md
# parking_lane_ctrl

Multi-lane parking gate controller. It generalises the single entry/exit gate FSM to `N_LANES` independent entry and exit lanes, with per-lane timeouts, a shared occupancy counter and capacity-limited admission arbitration. Each lane runs a concurrent entry FSM and exit FSM, and a global emergency input overrides all lanes. It sits between the lane sensors/payment units and the barrier actuators, and replaces the serialised single-gate controller.

## Interface
- `N_LANES`, 2: number of entry lanes, and equally of exit lanes (1..8).
- `CAPACITY`, 64: total spaces; must be ≤ 2^`CNT_W`−1.
- `CNT_W`, 8: occupancy / availability width.
- `TO_W`, 8: timeout counter width.
- `ENTRY_TIMEOUT`, 100: maximum cycles in E_OPEN (1..2^`TO_W`−1).
- `EXIT_TIMEOUT`, 100: maximum cycles in X_OPEN (1..2^`TO_W`−1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `entry_sensor` in `N_LANES`: vehicle present at entry lane i.
- `exit_sensor` in `N_LANES`: vehicle present at exit lane i.
- `payment_complete` in `N_LANES`: payment done for exit lane i (level).
- `emergency` in 1: global emergency (level).
- `open_entry` out `N_LANES`: entry barrier i open.
- `open_exit` out `N_LANES`: exit barrier i open.
- `calculate_fee` out `N_LANES`: fee calculation request, exit lane i.
- `occupancy` out `CNT_W`: occupied plus reserved spaces.
- `available_spaces` out `CNT_W`: `CAPACITY` − `occupancy`.
- `full` out 1: `occupancy` == `CAPACITY`.
- `emergency_active` out 1: global FSM is in EMERG.

## Operation
- All outputs are Moore-decoded from registered state, so no input-to-output combinational path exists.
- Reset values: all lanes in E_IDLE/X_IDLE, `occupancy`=0, `available_spaces`=`CAPACITY`, `full`=0, all open/fee outputs 0, `emergency_active`=0, timeout counters 0.
- Entry FSM, per lane:
  - E_IDLE → E_OPEN when the lane is granted.
  - E_OPEN (`open_entry`=1) → E_PASS when `entry_sensor` falls.
  - E_OPEN → E_WAIT on timeout.
  - E_PASS lasts 1 cycle, then → E_IDLE.
  - E_WAIT → E_IDLE once `entry_sensor`=0 (rearm, blocks retrigger).
- Grant: lane i is granted iff all of the following hold:
  - `entry_sensor[i]`=1 and the lane is in E_IDLE;
  - not in emergency;
  - the number of lanes j<i granted in the same cycle is < `available_spaces`.
  - Lowest index wins. Free space from exits completing this cycle is counted next cycle.
- A grant reserves a space: `occupancy` +1. An E_OPEN timeout refunds it: −1. E_PASS leaves the count unchanged.
- Exit FSM, per lane:
  - X_IDLE → X_PAY on `exit_sensor`=1.
  - X_PAY (`calculate_fee`=1) → X_OPEN on `payment_complete`.
  - X_PAY → X_IDLE if `exit_sensor` drops first (vehicle withdrew).
  - X_OPEN (`open_exit`=1) → X_PASS when `exit_sensor` falls.
  - X_OPEN → X_WAIT on timeout.
  - X_PASS lasts 1 cycle, `occupancy` −1, then → X_IDLE.
  - X_WAIT → X_IDLE once `exit_sensor`=0.
- Occupancy next = occupancy + grants − entry timeouts − X_PASS entries, computed in one adder per cycle.
  - The result clamps at 0: an underflow does not wrap.
  - An overflow past `CAPACITY` cannot occur by construction.
- Timeout counters are per lane and per direction.
  - They clear on entry to the OPEN state and increment while in it.
  - Timeout fires when the counter == TIMEOUT−1 and the sensor is still high, so OPEN lasts at most TIMEOUT cycles.
  - If the sensor falls and the timeout fires in the same cycle, pass wins.
- Emergency:
  - `emergency`=1 forces every lane to EMERG on the next edge: all `open_entry`/`open_exit`=1, `calculate_fee`=0, `emergency_active`=1.
  - Reservations held in E_OPEN are kept. No occupancy change occurs while in emergency.
  - Release (`emergency`=0) sends every lane to E_WAIT/X_WAIT.
  - Emergency takes priority over every other transition in the same cycle.
- `reset_n` asserted mid-operation immediately returns all state to reset values, including occupancy.

## Timing
- Sensor/grant at edge t → barrier open from t+1. Sensor fall at t → barrier closed at t+1; count update visible at t+2 for exit.
- Entry reservation is visible on `occupancy` at t+1.
- The `emergency` edge affects outputs 1 cycle later.
- Admission is throughput-limited only by the grant rule: up to `N_LANES` grants per cycle.

## Configuration
- `PARKING_STATUS_EN` defined adds the following ports:
  - `timeout_pulse` out 2·`N_LANES`: 1-cycle pulse on timeout; bits [`N_LANES`-1:0] entry, upper bits exit.
  - `count_err` out 1: sticky, set on occupancy clamp at 0, cleared only by reset.
- `PARKING_STATUS_EN` undefined: these ports and their logic are absent. Clamping behaviour is identical.

## Test plan
- **Basic entry:** reset, raise `entry_sensor[0]` for 5 cycles → `open_entry[0]` high cycles 1–5, `occupancy`=1, `available_spaces`=63.
- **Capacity arbitration:** `CAPACITY`=1, both `entry_sensor` rise together → only lane 0 opens, `full`=1; lane 1 opens 1 cycle after lane 0 times out.
- **Entry timeout:** `ENTRY_TIMEOUT`=4, hold sensor high → `open_entry` high exactly 4 cycles, `occupancy` returns to 0, and stays closed until the sensor drops and re-rises.
- **Full exit:** occupancy 3, exit lane 1 sensor → `calculate_fee[1]`; `payment_complete[1]` → `open_exit[1]`; sensor falls → `occupancy`=2.
- **Emergency override:** emergency mid X_PAY → all barriers open next cycle, fee 0, occupancy frozen; release → lanes idle only after their sensors are low.
- **Underflow and mid-run reset:** exit with occupancy 0 → occupancy stays 0, `count_err`=1 (with macro). `reset_n` low mid-E_OPEN → all outputs at reset values.
